// File: rtl/riscv_irq_source_arbiter.sv
// riscv_irq_source_arbiter
//   Event-unit side of the core interrupt interface. Captures 32 interrupt
//   event lines (edge or level) plus software set pulses into a pending
//   register. Selects the highest-index unmasked pending source and presents
//   irq/id/sec to the core. Clears the pending bit named by the core's ack.
//   After an ack, a hold-off window keeps the request low so the core can
//   return to idle.
//
// Parameters
//   ACK_HOLDOFF  cycles the request is held low after an ack (1..15)
//   EDGE_TRIG    1: rising edge of a line sets pending, 0: line level sets it
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   irq_lines_i[31:0] interrupt event lines, bit n = source id n
//   sw_set_i[31:0]    software set, bit n sets pending[n]
//   irq_mask_i[31:0]  1 = source may raise a request
//   irq_sec_mask_i    1 = source is secure (drives irq_sec_o)
//   irq_o             interrupt request to core
//   irq_id_o[4:0]     id of the requested source
//   irq_sec_o         secure bit of the requested source
//   irq_ack_i         single-cycle ack from core
//   irq_ack_id_i[4:0] id being acknowledged
//   pending_o[31:0]   current pending register
//   ack_err_o         one-cycle pulse: ack of an id that was not pending
module riscv_irq_source_arbiter #(
  parameter int ACK_HOLDOFF = 2,
  parameter bit EDGE_TRIG   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] irq_lines_i,
  input  logic [31:0] sw_set_i,
  input  logic [31:0] irq_mask_i,
  input  logic [31:0] irq_sec_mask_i,
  output logic        irq_o,
  output logic [4:0]  irq_id_o,
  output logic        irq_sec_o,
  input  logic        irq_ack_i,
  input  logic [4:0]  irq_ack_id_i,
  output logic [31:0] pending_o,
  output logic        ack_err_o
);

  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] line_p0;
  logic [31:0] pending;

  logic [31:0] ev;
  logic [31:0] ack_clr;
  logic [31:0] pending_next;
  logic [31:0] req_vec;
  logic [4:0]  winner;

  // Highest set index wins; the loop lets later (higher) bits overwrite.
  function automatic logic [4:0] pick_highest(input logic [31:0] v);
    logic [4:0] w;
    w = '0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) w = 5'(i);
    end
    return w;
  endfunction

  // Capture stage: events OR'd in after the ack clear so a same-cycle
  // set and ack on one bit leaves the bit pending.
  always_comb begin
    ev = '0;
    if (EDGE_TRIG) ev = irq_lines_i & ~line_p0;
    else           ev = irq_lines_i;
    ev = ev | sw_set_i;
    ack_clr = '0;
    if (irq_ack_i) ack_clr[irq_ack_id_i] = 1'b1;
    pending_next = (pending & ~ack_clr) | ev;
  end

  // Arbitration stage: from the registered pending and the live mask.
  assign req_vec = pending & irq_mask_i;
  assign winner  = pick_highest(req_vec);

  assign pending_o = pending;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending   <= '0;
      line_p0   <= '0;
      state     <= IDLE;
      cnt       <= '0;
      irq_o     <= 1'b0;
      irq_id_o  <= '0;
      irq_sec_o <= 1'b0;
      ack_err_o <= 1'b0;
    end else begin
      pending   <= pending_next;
      line_p0   <= irq_lines_i;
      // Error is judged on the pending bit before this cycle's clear.
      ack_err_o <= irq_ack_i & ~pending[irq_ack_id_i];

      // Request stage
      case (state)
        IDLE: begin
          if (|req_vec) begin
            state     <= REQ;
            irq_o     <= 1'b1;
            irq_id_o  <= winner;
            irq_sec_o <= irq_sec_mask_i[winner];
          end
        end
        REQ: begin
          if (irq_ack_i) begin
            state <= HOLD;
            cnt   <= 4'(ACK_HOLDOFF - 1);
            irq_o <= 1'b0;
          end else if (req_vec == '0) begin
            // Id/sec are left as they were; only the request drops.
            state <= IDLE;
            irq_o <= 1'b0;
          end else begin
            // Reloaded every cycle so a higher source preempts before ack.
            irq_id_o  <= winner;
            irq_sec_o <= irq_sec_mask_i[winner];
          end
        end
        HOLD: begin
          irq_o <= 1'b0;
          if (cnt == 4'd0) state <= IDLE;
          else             cnt   <= cnt - 4'd1;
        end
        default: begin
          state <= IDLE;
          irq_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
